// File: rtl/param_mem.sv
// Single-port word memory with byte-enabled writes, an RD_LAT-deep read pipeline,
// and a self-initialising phase that fills every word with INIT_VAL after reset.
module param_mem #(
  parameter int              DW       = 16,
  parameter int              AW       = 16,
  parameter int              DEPTH    = 2 ** AW,
  parameter int              RD_LAT   = 1,
  parameter logic [DW-1:0]   INIT_VAL = {DW{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [DW/8-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int          BW      = DW / 8;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW + 1)'(DEPTH - 1);
  localparam logic [0:0]  ST_INIT = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic [BW-1:0]     mem_wbe;
  logic [RD_LAT-1:0] vld_q, vld_d, err_q, err_d;
  logic [DW-1:0]     dat_q [RD_LAT];
  logic [DW-1:0]     dat_d [RD_LAT];
  logic              acc, in_range, rd_acc, wr_acc;

  assign acc      = req_valid && (state_q == ST_RUN);
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign rd_acc   = acc && !req_wr;
  assign wr_acc   = acc && req_wr && in_range && (req_be != {BW{1'b0}});

  // FSM next state and the single memory write port (init fill or accepted write)
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = INIT_VAL;
    mem_wbe   = {BW{1'b1}};
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if ({1'b0, cnt_q} == LAST_W) begin
          state_d = ST_RUN;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d   = cnt_q + AW'(1'b1);
        end
      end
      ST_RUN: begin
        if (wr_acc) begin
          mem_we    = 1'b1;
          mem_waddr = req_addr;
          mem_wdata = req_wdata;
          mem_wbe   = req_be;
        end else begin
          mem_we    = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // Read pipeline: stage 0 captures the word at acceptance, later stages shift it along
  always_comb begin
    vld_d    = vld_q;
    err_d    = err_q;
    dat_d    = dat_q;
    vld_d[0] = rd_acc;
    err_d[0] = rd_acc && !in_range;
    if (rd_acc && in_range) begin
      dat_d[0] = mem_q[req_addr];
    end else begin
      dat_d[0] = {DW{1'b0}};
    end
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      err_d[k] = err_q[k-1];
      dat_d[k] = dat_q[k-1];
    end
  end

  // Control and pipeline registers; idle stages carry zero data so outputs are clean
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= {AW{1'b0}};
      vld_q   <= {RD_LAT{1'b0}};
      err_q   <= {RD_LAT{1'b0}};
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= {DW{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  // Storage array: contents are not reset, the INIT phase rewrites every word
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (mem_wbe[i]) begin
          mem_q[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_err   = err_q[RD_LAT-1];
  assign rsp_rdata = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_param_mem.sv
// Bench for param_mem: vector table, reset/init sequences and random traffic,
// with read responses checked through an expected-response queue.
module tb_param_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid, rsp_err, init_done;
  logic [15:0] rsp_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        e;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] exp_d;
    logic        exp_e;
  } vec_t;
  vec_t vecs[21];

  logic [15:0] ref_mem [256];

  param_mem #(
    .DW(16), .AW(8), .DEPTH(200), .RD_LAT(2), .INIT_VAL(16'hA5A5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA5A5;
  endtask

  // Drive one request for one cycle; reads push their expected response
  task automatic issue(input logic wr, input logic [7:0] a, input logic [15:0] wd,
                       input logic [1:0] be, input logic use_tbl,
                       input logic [15:0] td, input logic te);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    if (wr) begin
      if (a < 8'd200) begin
        for (int b = 0; b < 2; b++) begin
          if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
    end else begin
      e.due = cyc + 2;
      if (use_tbl) begin
        e.d = td;
        e.e = te;
      end else if (a < 8'd200) begin
        e.d = ref_mem[a];
        e.e = 1'b0;
      end else begin
        e.d = 16'h0000;
        e.e = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom_range(0, 255));
    req_wdata = 16'($urandom);
    req_be    = 2'($urandom_range(0, 3));
  endtask

  task automatic check_reset_state();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_rsp_err",   rsp_err,   1'b0);
  endtask

  // Count cycles from reset release until init_done; requests stay ignored meanwhile
  task automatic wait_init(input string nm);
    int n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (!init_done) chk({nm, "_ready_low"}, req_ready, 1'b0);
    end
    req_valid = 1'b0;
    chk({nm, "_cycles"}, n, 200);
    chk({nm, "_ready"}, req_ready, 1'b1);
  endtask

  // Response monitor: pops the queue on every rsp_valid and flags missing responses
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (rst_n === 1'b1 || rsp_valid !== 1'b0) begin
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("extra_rsp", rsp_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_rdata", rsp_rdata, e.d);
          chk("rsp_err",   rsp_err,   e.e);
        end
      end else begin
        chk("idle_zero", {rsp_err, rsp_rdata}, 17'h00000);
        if (q.size() > 0 && q[0].due < cyc) begin
          chk("missing_rsp", cyc, q[0].due);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 16'hA5A5, 1'b0};
    vecs[1]  = '{1'b0, 8'd99,  16'h0000, 2'b00, 16'hA5A5, 1'b0};
    vecs[2]  = '{1'b0, 8'd199, 16'h0000, 2'b00, 16'hA5A5, 1'b0};
    vecs[3]  = '{1'b1, 8'h10,  16'h1234, 2'b11, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 8'h10,  16'hFFFF, 2'b01, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 8'h10,  16'h0000, 2'b00, 16'h12FF, 1'b0};
    vecs[6]  = '{1'b1, 8'd1,   16'h0001, 2'b11, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 8'd2,   16'h0002, 2'b11, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 8'd3,   16'h0003, 2'b11, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 8'd1,   16'h0000, 2'b00, 16'h0001, 1'b0};
    vecs[10] = '{1'b0, 8'd2,   16'h0000, 2'b00, 16'h0002, 1'b0};
    vecs[11] = '{1'b0, 8'd3,   16'h0000, 2'b00, 16'h0003, 1'b0};
    vecs[12] = '{1'b1, 8'd250, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
    vecs[13] = '{1'b0, 8'd250, 16'h0000, 2'b00, 16'h0000, 1'b1};
    vecs[14] = '{1'b0, 8'd199, 16'h0000, 2'b00, 16'hA5A5, 1'b0};
    vecs[15] = '{1'b1, 8'd20,  16'h1111, 2'b00, 16'h0000, 1'b0};
    vecs[16] = '{1'b0, 8'd20,  16'h0000, 2'b00, 16'hA5A5, 1'b0};
    vecs[17] = '{1'b1, 8'd199, 16'hBBCC, 2'b10, 16'h0000, 1'b0};
    vecs[18] = '{1'b0, 8'd199, 16'h0000, 2'b00, 16'hBBA5, 1'b0};
    vecs[19] = '{1'b0, 8'h10,  16'h0000, 2'b00, 16'h12FF, 1'b0};
    vecs[20] = '{1'b0, 8'd200, 16'h0000, 2'b00, 16'h0000, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000; req_be = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init");

    for (int i = 0; i < 21; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, 1'b1, vecs[i].exp_d, vecs[i].exp_e);
    end
    repeat (4) idle();

    // Reset right behind an accepted read, then a second reset partway through INIT
    issue(1'b0, 8'h10, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reinit_rst_ready", req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h10; req_wdata = 16'h0000; req_be = 2'b11;
    wait_init("reinit");
    model_reset();
    issue(1'b0, 8'h10, 16'h0000, 2'b00, 1'b1, 16'hA5A5, 1'b0);
    issue(1'b0, 8'd0,  16'h0000, 2'b00, 1'b1, 16'hA5A5, 1'b0);
    repeat (4) idle();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 209)), 16'($urandom),
              2'($urandom_range(0, 3)), 1'b0, 16'h0000, 1'b0);
      end
    end
    repeat (6) idle();
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
